// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer writer.
package fb_pkg;

    localparam int DEF_COLS = 64;
    localparam int DEF_ROWS = 32;

    // RGB444 pixel: [11:8]=B, [7:4]=G, [3:0]=R
    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,
        ST_PEND  = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

endpackage

// File: rtl/fb_writer.sv
// Raster pixel stream to split top/bottom frame memories, one-cycle write latency.
// FB_DBL_BUF_EN enables bank ping-pong gated by the display frame_sync pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_WRITE | accepting pixels into w_bank
// ST_PEND  | frame complete, stalled until display frame_sync
// ST_SWAP  | one cycle: toggle banks, clear counters
module fb_writer
    import fb_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    localparam int CB = $clog2(COLS),
    localparam int RB = $clog2(ROWS),
    localparam int AW = CB + RB - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  rgb444_t       s_data,
    input  logic          s_last,
    input  logic          frame_sync,
    output logic          w_en_top,
    output logic          w_en_btm,
    output logic [AW-1:0] w_addr,
    output rgb444_t       w_data,
    output logic          w_bank,
    output logic          rd_bank,
    output logic          err
);

    state_t          state_q, state_d;
    logic [CB-1:0]   col_q, col_d;
    logic [RB-1:0]   row_q, row_d;
    logic            s_ready_q, s_ready_d;
    logic            w_bank_q, w_bank_d;
    logic            err_q, err_d;
    logic            w_en_top_q, w_en_top_d;
    logic            w_en_btm_q, w_en_btm_d;
    logic [AW-1:0]   w_addr_q, w_addr_d;
    rgb444_t         w_data_q, w_data_d;
    logic            acc;
    logic            at_final;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        w_bank_d   = w_bank_q;
        err_d      = err_q;
        acc        = s_valid & s_ready_q;
        at_final   = (col_q == CB'(COLS - 1)) && (row_q == RB'(ROWS - 1));

        // Row MSB selects the half; remaining row bits index within it.
        w_en_top_d = acc & ~row_q[RB-1];
        w_en_btm_d = acc & row_q[RB-1];
        w_addr_d   = acc ? {row_q[RB-2:0], col_q} : w_addr_q;
        w_data_d   = acc ? s_data : w_data_q;

        case (state_q)
            ST_WRITE: begin
                if (acc) begin
                    if (at_final) begin
                        err_d = err_q | ~s_last;
                        col_d = '0;
                        row_d = '0;
`ifdef FB_DBL_BUF_EN
                        state_d = ST_PEND;
`endif
                    end else if (s_last) begin
                        err_d = 1'b1;
                        col_d = '0;
                        row_d = '0;
                    end else if (col_q == CB'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (frame_sync) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                state_d  = ST_WRITE;
                w_bank_d = ~w_bank_q;
                col_d    = '0;
                row_d    = '0;
            end
            default: state_d = ST_WRITE;
        endcase

        s_ready_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WRITE;
            col_q      <= '0;
            row_q      <= '0;
            s_ready_q  <= 1'b0;
            w_bank_q   <= 1'b0;
            err_q      <= 1'b0;
            w_en_top_q <= 1'b0;
            w_en_btm_q <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            s_ready_q  <= s_ready_d;
            w_bank_q   <= w_bank_d;
            err_q      <= err_d;
            w_en_top_q <= w_en_top_d;
            w_en_btm_q <= w_en_btm_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign w_en_top = w_en_top_q;
    assign w_en_btm = w_en_btm_q;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;
    assign err      = err_q;
    assign w_bank   = w_bank_q;
`ifdef FB_DBL_BUF_EN
    assign rd_bank  = ~w_bank_q;
`else
    // Single buffer: SWAP is unreachable, so the bank flop stays 0.
    assign rd_bank  = w_bank_q;
`endif

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter COLS, default 64, pixels per row; power of two.
REQ-002 Parameter ROWS, default 32, rows per frame; power of two, two halves of ROWS/2 (top/bottom).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s_valid  input  1  input pixel valid.
REQ-006 s_ready  output  1  block accepts pixel this cycle.
REQ-007 s_data  input  12  RGB444 pixel, [11:8]=B, [7:4]=G, [3:0]=R.
REQ-008 s_last  input  1  marks final pixel of frame.
REQ-009 frame_sync  input  1  one-cycle pulse from display side at end of displayed frame.
REQ-010 w_en_top / w_en_btm  output  1 each  write strobe, top-half / bottom-half memory.
REQ-011 w_addr  output  log2(COLS*ROWS/2)  write address {row[log2(ROWS/2)-1:0], col}.
REQ-012 w_data  output  12  pixel written.
REQ-013 w_bank  output  1  bank being written; rd_bank  output  1  bank display reads (always ~w_bank).
REQ-014 err  output  1  sticky framing error.

Function
REQ-015 Pixels accepted on s_valid & s_ready, raster order, col 0..COLS-1 then next row, row 0..ROWS-1.
REQ-016 Accepted pixel at (row, col) SHALL appear on w_* exactly one cycle later; rows < ROWS/2 -> w_en_top, else w_en_btm, address uses row mod ROWS/2.
REQ-017 w_en_top/w_en_btm SHALL be 0 in any cycle following no acceptance; never both 1.
REQ-018 States: WRITE (s_ready=1), PEND (s_ready=0, frame complete, awaiting frame_sync), SWAP (one cycle, s_ready=0, toggles w_bank/rd_bank, clears counters) -> WRITE.
REQ-019 WRITE -> PEND on acceptance of pixel COLS*ROWS-1 (last counter position), regardless of s_last.
REQ-020 PEND -> SWAP on frame_sync=1; frame_sync in WRITE or SWAP SHALL be ignored.
REQ-021 frame_sync in the same cycle as final-pixel acceptance SHALL be ignored; PEND waits for the next pulse.
REQ-022 s_last on a non-final pixel: err set, counters reset to (0,0) next cycle, no transition to PEND, no bank swap.
REQ-023 Final pixel accepted with s_last=0: err set, frame still completes normally.
REQ-024 Column counter wraps COLS-1 -> 0 with row increment; row counter never wraps except via SWAP or REQ-022.
REQ-025 err clears only on reset.

Reset
REQ-026 rst_n low: state WRITE, counters 0, w_bank=0, rd_bank=1, s_ready=0 while rst_n low then 1 the first cycle after release, w_en_*=0, w_addr=0, w_data=0, err=0.
REQ-027 Reset mid-frame discards partial frame; no write strobe after rst_n falls.

Configuration
REQ-028 Macro FB_DBL_BUF_EN defined: double buffering per REQ-018..021.
REQ-029 FB_DBL_BUF_EN undefined: no PEND/SWAP; after final pixel counters return to (0,0) next cycle, s_ready stays 1, w_bank=0 and rd_bank=0 constant, frame_sync ignored.

Structure
REQ-030 Package fb_pkg SHALL hold typedef rgb444_t, state enum, default COLS/ROWS constants.
REQ-031 No sub-module; single module with counters, FSM and output register.

Verification
REQ-032 Reset release, stream 2048 pixels with s_data=index[11:0], s_last on last -> writes at top addr 0..1023 then btm 0..1023, each one cycle after acceptance; state PEND, s_ready=0.
REQ-033 In PEND pulse frame_sync -> one SWAP cycle, w_bank=1, rd_bank=0, s_ready=1 next cycle, next pixel written to top addr 0.
REQ-034 s_last on pixel 100 -> err=1, next accepted pixel written top addr 0, w_bank unchanged.
REQ-035 Random s_valid gaps (50%) -> write sequence identical to REQ-032, no strobe in idle cycles.
REQ-036 Assert rst_n low at pixel 1500 -> strobes stop immediately, after release first pixel to top addr 0, w_bank=0.
REQ-037 FB_DBL_BUF_EN undefined, two back-to-back frames -> s_ready never drops, pixel 2048 written top addr 0, rd_bank=0.
